// File: rtl/dataproc_pkg.sv
// Shared definitions for the data-processing controller: register map,
// CONTROL/STATUS bit positions, controller states and bus helpers.
package dataproc_pkg;

    localparam logic [31:0] DP_BASE_ADDR = 32'h0200_1000;

    // Register offsets inside the 32-byte window
    localparam logic [4:0] OFF_CONTROL  = 5'h00;
    localparam logic [4:0] OFF_STATUS   = 5'h04;
    localparam logic [4:0] OFF_CONFIG   = 5'h08;
    localparam logic [4:0] OFF_LENGTH   = 5'h0C;
    localparam logic [4:0] OFF_RESULT   = 5'h10;
    localparam logic [4:0] OFF_PROGRESS = 5'h14;

    // CONTROL bits
    localparam int CTL_START   = 0;
    localparam int CTL_ABORT   = 1;
    localparam int CTL_IRQ_EN  = 2;
    localparam int CTL_IRQ_CLR = 3;

    // STATUS bits
    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ABORTED = 2;
    localparam int ST_EMPTY   = 3;
    localparam int ST_FULL    = 4;
    localparam int ST_LEVEL   = 8;

    // Writable fields of CONFIG (mode [1:0], thresh [15:8])
    localparam logic [31:0] CONFIG_MASK = 32'h0000_FF03;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Expand byte strobes into a bit mask
    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

endpackage

// File: rtl/dataproc_result_fifo.sv
// Synchronous result FIFO. Pointers wrap naturally (depth is a power of two);
// the level counter disambiguates full from empty. level_nxt_o lets the
// owner register flow control against the level of the coming cycle.
module dataproc_result_fifo #(
    parameter int RES_W      = 16,
    parameter int FIFO_DEPTH = 16,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int LW        = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [RES_W-1:0] data_i,
    input  logic             pop_i,
    output logic [RES_W-1:0] head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [LW-1:0]    level_o,
    output logic [LW-1:0]    level_nxt_o
);

    logic [RES_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [LW-1:0]    level_q;
    logic             push_ok, pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(FIFO_DEPTH));
    assign level_o = level_q;
    assign head_o  = mem_q[rd_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Next level: clear wins, simultaneous push+pop leaves it unchanged
    always_comb begin
        level_nxt_o = level_q;
        if (clr_i) level_nxt_o = '0;
        else       level_nxt_o = level_q + LW'(push_ok) - LW'(pop_ok);
    end

    // Pointer and level state
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop_ok)  rd_q <= rd_q + AW'(1);
            level_q <= level_nxt_o;
        end
    end

    // Storage; contents are don't-care while the level says empty
    always_ff @(posedge clk) begin
        if (push_ok && !clr_i && !reset) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/dataproc_ctrl.sv
// Memory-mapped sequencer for the data-processing core: register window on
// the picorv32 native bus, pixel gating during a job, result buffering.
module dataproc_ctrl
    import dataproc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DP_BASE_ADDR,
    parameter int          FIFO_DEPTH = 16,
    parameter int          PIX_W      = 8,
    parameter int          RES_W      = 16,
    localparam int         LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    output logic             mem_ready,
    output logic [31:0]      mem_rdata,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic             pix_ready,
    output logic             core_in_valid,
    output logic [PIX_W-1:0] core_in_data,
    input  logic             core_in_ready,
    input  logic             core_out_valid,
    input  logic [RES_W-1:0] core_out_data,
    output logic             core_out_ready,
    output logic [1:0]       core_mode,
    output logic [7:0]       core_thresh,
    output logic             core_flush,
    output logic             irq
);

    state_e      state_q, state_d;
    logic        ack_q, irq_en_q, done_q, done_d, aborted_q, aborted_d;
    logic        flush_q, flush_d, out_rdy_q, out_rdy_d;
    logic [31:0] rdata_q, rdata_d, rd_val, wmask, cfg_q;
    logic [15:0] len_q, sent_q, sent_d, recv_q, recv_d;

    logic sel, acc, wr, rd, ctl_wr, start_req, abort_req, clr_req;
    logic busy, busy_nxt, pix_hs, push, pop, fifo_clr;
    logic             fifo_empty, fifo_full;
    logic [RES_W-1:0] fifo_head;
    logic [LW-1:0]    fifo_level, fifo_level_nxt;

    // One access per request: accept only when not already acknowledging
    assign sel       = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]);
    assign acc       = sel && !ack_q;
    assign wr        = acc && (mem_wstrb != 4'b0);
    assign rd        = acc && (mem_wstrb == 4'b0);
    assign wmask     = strb_mask(mem_wstrb);
    assign ctl_wr    = wr && (mem_addr[4:0] == OFF_CONTROL) && mem_wstrb[0];
    assign start_req = ctl_wr && mem_wdata[CTL_START];
    assign abort_req = ctl_wr && mem_wdata[CTL_ABORT];
    assign clr_req   = ctl_wr && mem_wdata[CTL_IRQ_CLR];

    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign busy_nxt = (state_d == RUN) || (state_d == DRAIN);
    assign pix_hs   = (state_q == RUN) && pix_valid && core_in_ready;
    assign push     = busy && core_out_valid && out_rdy_q;
    assign pop      = rd && (mem_addr[4:0] == OFF_RESULT) && !fifo_empty;

    // Pixel path is a straight pass-through only while running
    assign pix_ready      = (state_q == RUN) && core_in_ready;
    assign core_in_valid  = (state_q == RUN) && pix_valid;
    assign core_in_data   = (state_q == RUN) ? pix_data : '0;
    assign core_out_ready = out_rdy_q;
    assign core_mode      = cfg_q[1:0];
    assign core_thresh    = cfg_q[15:8];
    assign core_flush     = flush_q;
    assign irq            = done_q && irq_en_q;
    assign mem_ready      = ack_q;
    assign mem_rdata      = ack_q ? rdata_q : 32'h0;

    dataproc_result_fifo #(
        .RES_W      (RES_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (fifo_clr),
        .push_i      (push),
        .data_i      (core_out_data),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .level_o     (fifo_level),
        .level_nxt_o (fifo_level_nxt)
    );

    // Job sequencing, status flags and counters
    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        flush_d   = 1'b0;
        fifo_clr  = 1'b0;
        sent_d    = pix_hs ? sent_q + 16'd1 : sent_q;
        recv_d    = push ? recv_q + 16'd1 : recv_q;
        if (clr_req) begin
            done_d    = 1'b0;
            aborted_d = 1'b0;
        end
        case (state_q)
            IDLE, DONE: begin
                if (start_req) begin
                    sent_d    = '0;
                    recv_d    = '0;
                    fifo_clr  = 1'b1;
                    aborted_d = 1'b0;
                    done_d    = (len_q == '0);
                    state_d   = (len_q == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort_req) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                    flush_d   = 1'b1;
                end else if (pix_hs && (sent_q + 16'd1 == len_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_req) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                    flush_d   = 1'b1;
                end else if (recv_q == len_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outside a job results are sunk, so keep the core unblocked
        out_rdy_d = busy_nxt ? (fifo_level_nxt != LW'(FIFO_DEPTH)) : 1'b1;
    end

    // Read mux, registered into the acknowledge cycle
    always_comb begin
        rd_val = 32'h0;
        case (mem_addr[4:0])
            OFF_CONTROL:  rd_val[CTL_IRQ_EN] = irq_en_q;
            OFF_STATUS: begin
                rd_val[ST_BUSY]           = busy;
                rd_val[ST_DONE]           = done_q;
                rd_val[ST_ABORTED]        = aborted_q;
                rd_val[ST_EMPTY]          = fifo_empty;
                rd_val[ST_FULL]           = fifo_full;
                rd_val[ST_LEVEL +: 5]     = 5'(fifo_level);
            end
            OFF_CONFIG:   rd_val = cfg_q;
            OFF_LENGTH:   rd_val = {16'h0, len_q};
            OFF_RESULT:   rd_val = fifo_empty ? 32'h0 : 32'(fifo_head);
            OFF_PROGRESS: rd_val = {recv_q, sent_q};
            default:      rd_val = 32'h0;
        endcase
        rdata_d = rd ? rd_val : 32'h0;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Bus, configuration, flag and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            flush_q   <= 1'b0;
            out_rdy_q <= 1'b0;
            cfg_q     <= '0;
            len_q     <= '0;
            sent_q    <= '0;
            recv_q    <= '0;
        end else begin
            ack_q     <= acc;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            flush_q   <= flush_d;
            out_rdy_q <= out_rdy_d;
            sent_q    <= sent_d;
            recv_q    <= recv_d;
            if (ctl_wr) irq_en_q <= mem_wdata[CTL_IRQ_EN];
            if (wr && !busy && (mem_addr[4:0] == OFF_CONFIG))
                cfg_q <= (cfg_q & ~(wmask & CONFIG_MASK)) | (mem_wdata & wmask & CONFIG_MASK);
            if (wr && !busy && (mem_addr[4:0] == OFF_LENGTH))
                len_q <= (len_q & ~wmask[15:0]) | (mem_wdata[15:0] & wmask[15:0]);
        end
    end

endmodule

// File: tb/tb_dataproc_ctrl.sv
// Directed bench for dataproc_ctrl: bus tasks plus a pixel source and an
// echoing core model, with per-scenario tasks checking hand-computed values.
module tb_dataproc_ctrl;

    localparam logic [31:0] BA = 32'h0200_1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = '0;
    logic        pix_ready;
    logic        core_in_valid;
    logic [7:0]  core_in_data;
    logic        core_in_ready = 1'b1;
    logic        core_out_valid = 1'b0;
    logic [15:0] core_out_data = '0;
    logic        core_out_ready;
    logic [1:0]  core_mode;
    logic [7:0]  core_thresh;
    logic        core_flush;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int flush_cnt = 0;
    int civ_cnt = 0;
    logic [7:0] src_q[$];
    logic [7:0] echo_q[$];

    dataproc_ctrl dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .core_in_valid(core_in_valid), .core_in_data(core_in_data),
        .core_in_ready(core_in_ready), .core_out_valid(core_out_valid),
        .core_out_data(core_out_data), .core_out_ready(core_out_ready),
        .core_mode(core_mode), .core_thresh(core_thresh),
        .core_flush(core_flush), .irq(irq)
    );

    always #5 clk = ~clk;

    // Pixel source and echoing core: drive after negedge, sample just before posedge
    always begin
        @(negedge clk);
        pix_valid      = src_q.size() > 0;
        pix_data       = (src_q.size() > 0) ? src_q[0] : 8'h0;
        core_out_valid = echo_q.size() > 0;
        core_out_data  = (echo_q.size() > 0) ? {8'h0, echo_q[0]} : 16'h0;
        #4;
        if (core_in_valid && core_in_ready) echo_q.push_back(core_in_data);
        if (pix_valid && pix_ready) void'(src_q.pop_front());
        if (core_out_valid && core_out_ready) void'(echo_q.pop_front());
        if (core_flush) flush_cnt++;
        if (core_in_valid) civ_cnt++;
    end

    task automatic bus_write(input logic [4:0] off, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = BA + 32'(off); mem_wdata = d; mem_wstrb = 4'hF;
        do begin @(posedge clk); #1; n++; end while (!mem_ready && n < 8);
        if (!mem_ready) begin
            errors++;
            $display("FAIL bus_write_ack off=%h: no mem_ready within 8 cycles", off);
        end
        mem_valid = 1'b0; mem_wstrb = 4'h0;
    endtask

    task automatic bus_read(input logic [4:0] off, output logic [31:0] d);
        int n = 0;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = BA + 32'(off); mem_wstrb = 4'h0;
        do begin @(posedge clk); #1; n++; end while (!mem_ready && n < 8);
        d = mem_rdata;
        if (!mem_ready) begin
            errors++;
            $display("FAIL bus_read_ack off=%h: no mem_ready within 8 cycles", off);
        end
        mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mem_ready, mem_rdata, pix_ready, core_in_valid, core_in_data, core_out_ready,
             core_mode, core_thresh, core_flush, irq} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b rdata=%h cor=%b flush=%b irq=%b required all 0",
                     mem_ready, mem_rdata, core_out_ready, core_flush, irq);
        end
        @(negedge clk); reset = 1'b0;
        bus_read(5'h04, v);
        checks++;
        if (v !== 32'h0000_0008) begin errors++; $display("FAIL reset_status: got %h required 00000008", v); end
        bus_read(5'h14, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL reset_progress: got %h required 0", v); end
        bus_read(5'h1C, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h required 0", v); end
    endtask

    task automatic test_basic_job();
        logic [31:0] v;
        int n;
        bus_write(5'h08, 32'h0000_4001);
        bus_write(5'h0C, 32'd4);
        bus_write(5'h00, 32'h5);
        checks++;
        if (core_mode !== 2'd1 || core_thresh !== 8'h40) begin
            errors++; $display("FAIL basic_cfg: got mode=%0d thresh=%h required 1/40", core_mode, core_thresh);
        end
        bus_read(5'h04, v);
        checks++;
        if (v !== 32'h0000_0009) begin errors++; $display("FAIL basic_busy: got %h required 00000009", v); end
        for (int i = 0; i < 4; i++) src_q.push_back(8'h10 + 8'(i));
        n = 0;
        while (!irq && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq: got %b required 1", irq); end
        bus_read(5'h04, v);
        checks++;
        if (v !== 32'h0000_0402) begin errors++; $display("FAIL basic_done_status: got %h required 00000402", v); end
        bus_read(5'h14, v);
        checks++;
        if (v !== 32'h0004_0004) begin errors++; $display("FAIL basic_progress: got %h required 00040004", v); end
        for (int i = 0; i < 4; i++) begin
            bus_read(5'h10, v);
            checks++;
            if (v !== 32'h10 + 32'(i)) begin
                errors++; $display("FAIL basic_result%0d: got %h required %h", i, v, 32'h10 + 32'(i));
            end
        end
        bus_read(5'h10, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL basic_empty_result: got %h required 0", v); end
        bus_read(5'h04, v);
        checks++;
        if (v !== 32'h0000_000A) begin errors++; $display("FAIL basic_empty_status: got %h required 0000000a", v); end
        bus_write(5'h00, 32'h8);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_clr: got %b required 0", irq); end
    endtask

    task automatic test_fifo_full();
        logic [31:0] v;
        int n;
        bus_write(5'h0C, 32'd20);
        bus_write(5'h00, 32'h1);
        for (int i = 0; i < 20; i++) src_q.push_back(8'h20 + 8'(i));
        repeat (60) @(negedge clk);
        checks++;
        if (core_out_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b required 0", core_out_ready); end
        bus_read(5'h04, v);
        checks++;
        if (v !== 32'h0000_1011) begin errors++; $display("FAIL full_status: got %h required 00001011", v); end
        bus_read(5'h14, v);
        checks++;
        if (v !== 32'h0010_0014) begin errors++; $display("FAIL full_progress: got %h required 00100014", v); end
        for (int i = 0; i < 20; i++) begin
            bus_read(5'h10, v);
            checks++;
            if (v !== 32'h20 + 32'(i)) begin
                errors++; $display("FAIL full_result%0d: got %h required %h", i, v, 32'h20 + 32'(i));
            end
        end
        n = 0;
        do begin bus_read(5'h04, v); n++; end while (!v[1] && n < 10);
        checks++;
        if (v !== 32'h0000_000A) begin errors++; $display("FAIL full_done_status: got %h required 0000000a", v); end
    endtask

    task automatic test_abort();
        logic [31:0] v;
        bus_write(5'h0C, 32'd8);
        bus_write(5'h00, 32'h5);
        for (int i = 0; i < 3; i++) src_q.push_back(8'h40 + 8'(i));
        repeat (10) @(negedge clk);
        flush_cnt = 0;
        bus_write(5'h00, 32'h6);
        repeat (3) @(negedge clk);
        checks++;
        if (flush_cnt !== 1) begin errors++; $display("FAIL abort_flush: got %0d cycles required 1", flush_cnt); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL abort_irq: got %b required 0", irq); end
        bus_read(5'h04, v);
        checks++;
        if (v !== 32'h0000_0304) begin errors++; $display("FAIL abort_status: got %h required 00000304", v); end
        bus_read(5'h14, v);
        checks++;
        if (v !== 32'h0003_0003) begin errors++; $display("FAIL abort_progress: got %h required 00030003", v); end
        bus_write(5'h00, 32'h8);
        bus_read(5'h04, v);
        checks++;
        if (v !== 32'h0000_0300) begin errors++; $display("FAIL abort_clr: got %h required 00000300", v); end
    endtask

    task automatic test_zero_len();
        logic [31:0] v;
        bus_write(5'h0C, 32'd0);
        src_q.push_back(8'h55);
        repeat (2) @(negedge clk);
        civ_cnt = 0;
        bus_write(5'h00, 32'h5);
        bus_read(5'h04, v);
        checks++;
        if (v !== 32'h0000_000A) begin errors++; $display("FAIL zero_status: got %h required 0000000a", v); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL zero_irq: got %b required 1", irq); end
        checks++;
        if (civ_cnt !== 0) begin errors++; $display("FAIL zero_core_in_valid: got %0d cycles required 0", civ_cnt); end
        bus_write(5'h00, 32'h8);
        src_q.delete();
    endtask

    task automatic test_busy_ignore();
        logic [31:0] v;
        bus_write(5'h08, 32'h0000_2002);
        bus_write(5'h0C, 32'd5);
        bus_write(5'h00, 32'h1);
        src_q.push_back(8'h61); src_q.push_back(8'h62);
        repeat (8) @(negedge clk);
        bus_write(5'h0C, 32'd99);
        bus_write(5'h08, 32'h0000_FF03);
        bus_write(5'h00, 32'h1);
        bus_read(5'h0C, v);
        checks++;
        if (v !== 32'd5) begin errors++; $display("FAIL busy_length: got %h required 00000005", v); end
        bus_read(5'h08, v);
        checks++;
        if (v !== 32'h0000_2002) begin errors++; $display("FAIL busy_config: got %h required 00002002", v); end
        bus_read(5'h14, v);
        checks++;
        if (v !== 32'h0002_0002) begin errors++; $display("FAIL busy_no_restart: got %h required 00020002", v); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] v;
        @(negedge clk);
        reset = 1'b1;
        src_q.delete(); echo_q.delete();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({core_flush, irq, core_out_ready, core_mode, core_thresh, pix_ready} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got flush=%b irq=%b cor=%b mode=%0d thr=%h prdy=%b required all 0",
                     core_flush, irq, core_out_ready, core_mode, core_thresh, pix_ready);
        end
        @(negedge clk); reset = 1'b0;
        bus_read(5'h04, v);
        checks++;
        if (v !== 32'h0000_0008) begin errors++; $display("FAIL midreset_status: got %h required 00000008", v); end
        bus_read(5'h14, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL midreset_progress: got %h required 0", v); end
        bus_read(5'h0C, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL midreset_length: got %h required 0", v); end
    endtask

    initial begin
        test_reset();
        test_basic_job();
        test_fifo_full();
        test_abort();
        test_zero_len();
        test_busy_ignore();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dataproc_ctrl.md
Name: dataproc_ctrl

Overview:
Memory-mapped controller that sequences the SoC data-processing core for the CPU. The CPU sets mode, threshold and job length, then writes START. The block gates a pixel stream into the core and counts the pixels sent and results returned. Results are buffered in a FIFO that the CPU pops by reading RESULT. The block sits on the picorv32 native memory bus at the DATAPROC_CONTROL window (0x0200_1000), between the bus and the core.

Parameters:
BASE_ADDR  32'h0200_1000  base of the 32-byte register window
FIFO_DEPTH  16  result FIFO entries; must be a power of two, at least 2
PIX_W  8  pixel width into the core
RES_W  16  result width from the core

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mem_valid  in  1  bus request
mem_addr  in  32  byte address
mem_wdata  in  32  write data
mem_wstrb  in  4  byte strobes; 0 means read
mem_ready  out  1  one-cycle acknowledge
mem_rdata  out  32  read data; 0 when mem_ready is low
pix_valid  in  1  source pixel valid
pix_data  in  PIX_W  source pixel
pix_ready  out  1  source pixel accept
core_in_valid  out  1  pixel to core valid
core_in_data  out  PIX_W  pixel to core
core_in_ready  in  1  core accepts pixel
core_out_valid  in  1  core result valid
core_out_data  in  RES_W  core result
core_out_ready  out  1  controller accepts result
core_mode  out  2  CONFIG[1:0]
core_thresh  out  8  CONFIG[15:8]
core_flush  out  1  one-cycle core pipeline flush
irq  out  1  job-complete interrupt, level

Behaviour:
- Reset value of every output is 0; state IDLE; all registers, counters and the FIFO cleared.
- Decode: sel = mem_valid && mem_addr[31:5] == BASE_ADDR[31:5].
  - mem_ready pulses for one cycle, the cycle after sel; a new ack only after mem_ready has dropped.
  - Unmapped offsets read 0, writes are dropped, and the access is still acked.
- Register map (offset, access, content):
  - 0x00 CONTROL, W:
    - bit0 START: pulse.
    - bit1 ABORT: pulse.
    - bit2 IRQ_EN: sticky, reads back at bit2.
    - bit3 IRQ_CLR: clears DONE and ABORTED.
  - 0x04 STATUS, R: bit0 busy, bit1 done, bit2 aborted, bit3 fifo_empty, bit4 fifo_full, [12:8] fifo level.
  - 0x08 CONFIG, RW: [1:0] mode, [15:8] thresh.
  - 0x0C LENGTH, RW: [15:0] N, the job pixel count.
  - 0x10 RESULT, R: FIFO head zero-extended; the read pops one entry. An empty FIFO reads 0 and does not pop.
  - 0x14 PROGRESS, R: [15:0] sent, [31:16] received.
- Writes to CONFIG/LENGTH while busy are ignored.
- START while busy is ignored.
- States and transitions:
  - IDLE/DONE: START clears sent, received, FIFO, DONE and ABORTED, then goes to RUN. If N==0, go straight to DONE instead.
  - RUN: pixel path is combinational pass-through.
    - pix_ready = core_in_ready.
    - core_in_valid = pix_valid.
    - core_in_data = pix_data.
    - sent increments on each core handshake.
    - When a handshake makes sent==N, go to DRAIN the next cycle; no further pixels pass.
  - DRAIN: pix_ready=0, core_in_valid=0. When received reaches N, go to DONE and set DONE.
  - ABORT in RUN or DRAIN: go to IDLE, set ABORTED, pulse core_flush for one cycle. FIFO contents are kept.
  - ABORT in IDLE/DONE has no effect.
- Results:
  - core_out_ready = !fifo_full, registered from the previous cycle's level minus pop.
  - Accepted only in RUN or DRAIN; results arriving in IDLE are dropped with core_out_ready=1.
  - received increments per accepted result.
- Simultaneous push and pop: level unchanged, head advances. Pop when empty: no-op. Push never occurs when full.
- busy = state is RUN or DRAIN.
- irq = DONE && IRQ_EN, level. Cleared by IRQ_CLR or START.
- Counters are 16 bits with no wrap, since N ≤ 65535.
- Reset mid-job: everything returns to reset values with no core_flush; the SoC resets the core itself.

Decomposition:
- dataproc_pkg holds:
  - register offsets;
  - CONTROL/STATUS bit positions;
  - state enum {IDLE, RUN, DRAIN, DONE};
  - BASE_ADDR default.
- One sub-module, dataproc_result_fifo: synchronous FIFO with push/pop/full/empty/level, parameterised on RES_W and FIFO_DEPTH.

Test Plan:
- Write CONFIG=0x0000_4001, LENGTH=4, CONTROL=0x5, then feed pixels 0x10..0x13 while the core echoes them as results -> core_mode=1, core_thresh=0x40; STATUS goes busy and then done=1; irq=1; PROGRESS=0x0004_0004; four RESULT reads return 0x10..0x13, and a fifth returns 0 with empty=1.
- LENGTH=20, FIFO_DEPTH=16, no RESULT reads -> core_out_ready drops after 16 results and the job stalls in DRAIN with fifo_full=1; reading 4 results completes the job and all 20 results are recovered in order.
- Start with N=8, ABORT after 3 pixels -> one-cycle core_flush, busy=0, aborted=1, PROGRESS[15:0]=3, irq stays 0.
- START with LENGTH=0 -> DONE the next cycle, core_in_valid never asserted.
- While busy, write LENGTH=99 and CONFIG, and issue START -> LENGTH and CONFIG read back unchanged and the job is not restarted.
- Assert reset mid-RUN -> all outputs and status bits read 0 the cycle after reset is released, and the FIFO is empty.
